// File: rtl/isa_pkg.sv
// ============================================================================
// isa_pkg : shared operand width, operand-select encoding and mux states
// Revision: 1.0
// ============================================================================
`default_nettype none

package isa_pkg;

  localparam int DATA_WIDTH = 16;

  // Operand-select encoding shared with the decode stage
  localparam int OPSEL_REGA = 0;
  localparam int OPSEL_REGB = 1;
  localparam int OPSEL_IMM  = 2;
  localparam int OPSEL_PC   = 3;

  // Encoded as {OutValid, SkidValid}
  typedef enum logic [1:0] {
    MUX_EMPTY = 2'b00,
    MUX_BUSY  = 2'b10,
    MUX_FULL  = 2'b11
  } mux_state_t;

endpackage

`default_nettype wire

// File: rtl/mux_n_1_comb.sv
// ============================================================================
// mux_n_1_comb : unregistered N:1 selector, forwards zero for out-of-range index
// Revision: 1.0
// ============================================================================
`default_nettype none

module mux_n_1_comb #(
  parameter int WIDTH      = 16,
  parameter int NUM_INPUTS = 4,
  parameter int SEL_WIDTH  = $clog2(NUM_INPUTS)
) (
  input  logic [WIDTH*NUM_INPUTS-1:0] operands,
  input  logic [SEL_WIDTH-1:0]        sel,
  output logic [WIDTH-1:0]            sel_data
);

  logic [31:0] sel_ext;

  assign sel_ext = 32'(sel);

  // Compare-and-OR form keeps indices >= NUM_INPUTS at zero without a range check
  always_comb begin
    sel_data = '0;
    for (int unsigned k = 0; k < NUM_INPUTS; k++) begin
      if (sel_ext == k) begin
        sel_data = operands[k*WIDTH +: WIDTH];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mux_n_1_pipe.sv
// ============================================================================
// mux_n_1_pipe : N:1 operand selector, registered output plus skid slot
// Optional: define MUX_SEL_CHECK_EN to add the sticky SelError output.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mux_n_1_pipe
  import isa_pkg::*;
#(
  parameter int WIDTH      = DATA_WIDTH,
  parameter int NUM_INPUTS = 4,
  parameter int SEL_WIDTH  = $clog2(NUM_INPUTS)
) (
  input  logic                        Clock,
  input  logic                        Reset,
  input  logic [WIDTH*NUM_INPUTS-1:0] Operands,
  input  logic [SEL_WIDTH-1:0]        Selector,
  input  logic                        InValid,
  output logic                        InReady,
  output logic [WIDTH-1:0]            Result,
  output logic                        OutValid,
  input  logic                        OutReady
`ifdef MUX_SEL_CHECK_EN
  ,
  output logic                        SelError
`endif
);

  mux_state_t       state_q;
  mux_state_t       state_d;
  logic [WIDTH-1:0] sel_data;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] skid_q;
  logic             in_fire;
  logic             out_fire;
  logic             load_main_sel;
  logic             load_main_skid;
  logic             load_skid;

  mux_n_1_comb #(
    .WIDTH      (WIDTH),
    .NUM_INPUTS (NUM_INPUTS),
    .SEL_WIDTH  (SEL_WIDTH)
  ) u_sel (
    .operands (Operands),
    .sel      (Selector),
    .sel_data (sel_data)
  );

  // Both handshake outputs come straight from the state flops
  assign OutValid = state_q[1];
  assign InReady  = ~state_q[0];
  assign Result   = result_q;
  assign in_fire  = InValid & InReady;
  assign out_fire = OutValid & OutReady;

  always_comb begin
    state_d        = state_q;
    load_main_sel  = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    unique case (state_q)
      MUX_EMPTY: begin
        if (in_fire) begin
          state_d       = MUX_BUSY;
          load_main_sel = 1'b1;
        end
      end
      MUX_BUSY: begin
        if (in_fire && out_fire) begin
          load_main_sel = 1'b1;
        end else if (in_fire) begin
          state_d   = MUX_FULL;
          load_skid = 1'b1;
        end else if (out_fire) begin
          state_d = MUX_EMPTY;
        end
      end
      MUX_FULL: begin
        if (out_fire) begin
          state_d        = MUX_BUSY;
          load_main_skid = 1'b1;
        end
      end
      default: begin
        state_d = MUX_EMPTY;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= MUX_EMPTY;
      result_q <= '0;
      skid_q   <= '0;
    end else begin
      state_q <= state_d;
      if (load_main_sel) begin
        result_q <= sel_data;
      end else if (load_main_skid) begin
        result_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= sel_data;
      end
    end
  end

`ifdef MUX_SEL_CHECK_EN
  logic sel_err_q;
  logic sel_oor;

  assign sel_oor  = (32'(Selector) >= 32'(NUM_INPUTS));
  assign SelError = sel_err_q;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      sel_err_q <= 1'b0;
    end else if (in_fire && sel_oor) begin
      sel_err_q <= 1'b1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mux_n_1_pipe.sv
// ============================================================================
// tb_mux_n_1_pipe : directed self-checking bench for mux_n_1_pipe
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mux_n_1_pipe;

  logic        clk = 1'b0;
  logic        rst;

  // 4-input instance
  logic [63:0] operands;
  logic [1:0]  selector;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] result;
  logic        out_valid;
  logic        out_ready;

  // 3-input instance for the out-of-range index
  logic [47:0] operands3;
  logic [1:0]  selector3;
  logic        in_valid3;
  logic        in_ready3;
  logic [15:0] result3;
  logic        out_valid3;
  logic        out_ready3;

`ifdef MUX_SEL_CHECK_EN
  logic        sel_error;
  logic        sel_error3;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mux_n_1_pipe #(.WIDTH(16), .NUM_INPUTS(4)) dut (
    .Clock    (clk),
    .Reset    (rst),
    .Operands (operands),
    .Selector (selector),
    .InValid  (in_valid),
    .InReady  (in_ready),
    .Result   (result),
    .OutValid (out_valid),
    .OutReady (out_ready)
`ifdef MUX_SEL_CHECK_EN
    ,
    .SelError (sel_error)
`endif
  );

  mux_n_1_pipe #(.WIDTH(16), .NUM_INPUTS(3)) dut3 (
    .Clock    (clk),
    .Reset    (rst),
    .Operands (operands3),
    .Selector (selector3),
    .InValid  (in_valid3),
    .InReady  (in_ready3),
    .Result   (result3),
    .OutValid (out_valid3),
    .OutReady (out_ready3)
`ifdef MUX_SEL_CHECK_EN
    ,
    .SelError (sel_error3)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks read there too
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Result must hold across any stalled cycle (reset edges excepted)
  logic        p_valid  = 1'b0;
  logic        p_ready  = 1'b0;
  logic        p_rst    = 1'b1;
  logic [15:0] p_result = '0;

  always @(negedge clk) begin
    if (p_valid === 1'b1 && p_ready === 1'b0 && p_rst === 1'b0) begin
      check("stall_hold", 32'(result), 32'(p_result));
    end
    p_valid  = out_valid;
    p_ready  = out_ready;
    p_rst    = rst;
    p_result = result;
  end

  initial begin
    rst        = 1'b1;
    operands   = 64'hDDDD_CCCC_BBBB_AAAA;
    selector   = 2'd0;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    operands3  = 48'hCCCC_BBBB_AAAA;
    selector3  = 2'd0;
    in_valid3  = 1'b0;
    out_ready3 = 1'b1;

    // Reset then idle
    step();
    step();
    rst = 1'b0;
    step();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_result",    32'(result),    32'd0);

    // Basic select
    selector = 2'd2;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("basic_result", 32'(result),    32'hCCCC);
    check("basic_valid",  32'(out_valid), 32'd1);
    step();
    check("basic_drain",  32'(out_valid), 32'd0);

    // Streaming, one accepted per cycle
    selector = 2'd0; in_valid = 1'b1;
    step();
    check("stream0", 32'(result), 32'hAAAA);
    check("stream0_v", 32'(out_valid), 32'd1);
    selector = 2'd1;
    step();
    check("stream1", 32'(result), 32'hBBBB);
    check("stream1_rdy", 32'(in_ready), 32'd1);
    selector = 2'd2;
    step();
    check("stream2", 32'(result), 32'hCCCC);
    selector = 2'd3;
    step();
    check("stream3", 32'(result), 32'hDDDD);
    check("stream3_v", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    step();
    check("stream_drain", 32'(out_valid), 32'd0);

    // Backpressure into the skid slot
    out_ready = 1'b0;
    selector  = 2'd1; in_valid = 1'b1;
    step();
    check("bp_first",     32'(result),   32'hBBBB);
    check("bp_first_rdy", 32'(in_ready), 32'd1);
    selector = 2'd3;
    step();
    check("bp_full_result", 32'(result),    32'hBBBB);
    check("bp_full_rdy",    32'(in_ready),  32'd0);
    check("bp_full_valid",  32'(out_valid), 32'd1);
    // Offered while full: must be ignored
    selector = 2'd0;
    step();
    check("bp_ignored_result", 32'(result),   32'hBBBB);
    check("bp_ignored_rdy",    32'(in_ready), 32'd0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    check("bp_skid_result", 32'(result),    32'hDDDD);
    check("bp_skid_valid",  32'(out_valid), 32'd1);
    check("bp_skid_rdy",    32'(in_ready),  32'd1);
    step();
    check("bp_drain", 32'(out_valid), 32'd0);

    // Out-of-range and in-range on the 3-input instance
    selector3 = 2'd3; in_valid3 = 1'b1;
    step();
    check("oor_result", 32'(result3),    32'h0000);
    check("oor_valid",  32'(out_valid3), 32'd1);
    selector3 = 2'd2;
    step();
    in_valid3 = 1'b0;
    check("n3_sel2", 32'(result3), 32'hCCCC);
`ifdef MUX_SEL_CHECK_EN
    check("selerr_set",    32'(sel_error3), 32'd1);
    check("selerr_other",  32'(sel_error),  32'd0);
    step();
    check("selerr_sticky", 32'(sel_error3), 32'd1);
`else
    step();
`endif
    check("n3_drain", 32'(out_valid3), 32'd0);

    // Reset while FULL
    out_ready = 1'b0;
    selector  = 2'd1; in_valid = 1'b1;
    step();
    selector = 2'd2;
    step();
    in_valid = 1'b0;
    check("pre_rst_full", 32'(in_ready), 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_valid",  32'(out_valid), 32'd0);
    check("midrst_rdy",    32'(in_ready),  32'd1);
    check("midrst_result", 32'(result),    32'd0);
`ifdef MUX_SEL_CHECK_EN
    check("selerr_cleared", 32'(sel_error3), 32'd0);
`endif
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("no_replay_valid",  32'(out_valid), 32'd0);
      check("no_replay_result", 32'(result),    32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
